// File: rtl/ship_count_arbiter.sv
// Ship-count arbiter: validates and locks one count per player, then resolves the minimum; DECISION_TIMEOUT_EN adds a COLLECT timeout.
// Latency: lock one cycle after the sampled confirm edge, decided two cycles after the last lock.
// No backpressure: confirm edges outside COLLECT or on locked players are dropped; abort/start-fall win over everything.
module ship_count_arbiter #(
  parameter int NUM_PLAYERS    = 2,
  parameter int CNT_W          = 3,
  parameter int MIN_SHIPS      = 1,
  parameter int MAX_SHIPS      = 5,
  parameter int TIMEOUT_CYCLES = 50_000_000,
  parameter int DEFAULT_SHIPS  = 3
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         abort,
  input  logic [NUM_PLAYERS*CNT_W-1:0] amount,
  input  logic [NUM_PLAYERS-1:0]       confirm,
  output logic [NUM_PLAYERS-1:0]       locked,
  output logic [NUM_PLAYERS-1:0]       reject,
  output logic [NUM_PLAYERS*CNT_W-1:0] player_counts,
  output logic [CNT_W-1:0]             final_count,
  output logic                         decided,
  output logic                         timed_out
);

  if (NUM_PLAYERS < 1 || NUM_PLAYERS > 8 || MAX_SHIPS >= (1 << CNT_W) || MIN_SHIPS > MAX_SHIPS ||
      TIMEOUT_CYCLES < 1 || DEFAULT_SHIPS < MIN_SHIPS || DEFAULT_SHIPS > MAX_SHIPS) begin : g_bad_cfg
    $error("ship_count_arbiter: illegal parameter set");
  end

  typedef enum logic [1:0] {IDLE, COLLECT, RESOLVE, DONE} state_t;

  state_t                   state, state_nxt;
  logic [NUM_PLAYERS-1:0]   confirm_q, rise, in_range, take, bad, force_lk;
  logic [CNT_W-1:0]         min_cnt;
  logic                     run;

  assign run  = start & ~abort;
  assign rise = confirm & ~confirm_q;

  always_comb begin
    in_range = '0;
    for (int i = 0; i < NUM_PLAYERS; i++)
      in_range[i] = (amount[i*CNT_W +: CNT_W] >= CNT_W'(MIN_SHIPS)) &&
                    (amount[i*CNT_W +: CNT_W] <= CNT_W'(MAX_SHIPS));
  end

  assign take = rise & ~locked & in_range;
  assign bad  = rise & ~locked & ~in_range;

  always_comb begin
    min_cnt = player_counts[CNT_W-1:0];
    for (int i = 1; i < NUM_PLAYERS; i++)
      if (player_counts[i*CNT_W +: CNT_W] < min_cnt)
        min_cnt = player_counts[i*CNT_W +: CNT_W];
  end

`ifdef DECISION_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_cnt;
  logic          tmo_hit;

  assign tmo_hit = (state == COLLECT) && (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));
  // A valid confirm in the timeout cycle keeps the player's own count.
  assign force_lk = tmo_hit ? (~locked & ~take) : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                  tmo_cnt <= '0;
    else if (state == COLLECT) tmo_cnt <= tmo_cnt + TW'(1);
    else                       tmo_cnt <= '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                timed_out <= 1'b0;
    else if (state == IDLE || !run)          timed_out <= 1'b0;
    else if (state == COLLECT && |force_lk)  timed_out <= 1'b1;
  end
`else
  assign force_lk  = '0;
  assign timed_out = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (run) state_nxt = COLLECT;
      COLLECT: if (!run) state_nxt = IDLE;
               else if (&locked) state_nxt = RESOLVE;
      RESOLVE: state_nxt = run ? DONE : IDLE;
      DONE:    if (!run) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      confirm_q     <= '0;
      locked        <= '0;
      reject        <= '0;
      player_counts <= '0;
      final_count   <= '0;
      decided       <= 1'b0;
    end else begin
      state     <= state_nxt;
      confirm_q <= confirm;
      reject    <= '0;
      decided   <= 1'b0;
      if (state == IDLE || !run) begin
        locked        <= '0;
        player_counts <= '0;
        final_count   <= '0;
      end else if (state == COLLECT) begin
        locked <= locked | take | force_lk;
        reject <= bad;
        for (int i = 0; i < NUM_PLAYERS; i++) begin
          if (take[i])
            player_counts[i*CNT_W +: CNT_W] <= amount[i*CNT_W +: CNT_W];
          else if (force_lk[i])
            player_counts[i*CNT_W +: CNT_W] <= CNT_W'(DEFAULT_SHIPS);
        end
      end else if (state == RESOLVE) begin
        final_count <= min_cnt;
        decided     <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ship_count_arbiter.sv
// Bench for ship_count_arbiter: directed scenarios with literal expectations plus random play against a game-level model.
module tb_ship_count_arbiter;
  localparam int NP = 2, CW = 3, MINS = 1, MAXS = 5, TMO = 20, DEF = 3;

  logic             clk = 1'b0;
  logic             rst, start, abort;
  logic [NP*CW-1:0] amount;
  logic [NP-1:0]    confirm, locked, reject;
  logic [NP*CW-1:0] player_counts;
  logic [CW-1:0]    final_count;
  logic             decided, timed_out;

  int total = 0, bad = 0;
  bit chk_en = 0;

  ship_count_arbiter #(.NUM_PLAYERS(NP), .CNT_W(CW), .MIN_SHIPS(MINS), .MAX_SHIPS(MAXS),
                       .TIMEOUT_CYCLES(TMO), .DEFAULT_SHIPS(DEF)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .amount(amount), .confirm(confirm),
    .locked(locked), .reject(reject), .player_counts(player_counts), .final_count(final_count),
    .decided(decided), .timed_out(timed_out));

  always #5 clk = ~clk;

  // Game model: phase 0 idle, 1 collecting, 2 resolving, 3 done.
  int m_phase = 0;
  bit m_lk[NP], m_rej[NP], m_cq[NP];
  int m_cnt[NP];
  int m_final = 0, m_ticks = 0;
  bit m_dec = 0, m_to = 0;

  task automatic model_reset();
    m_phase = 0; m_final = 0; m_ticks = 0; m_dec = 0; m_to = 0;
    for (int p = 0; p < NP; p++) begin
      m_lk[p] = 0; m_rej[p] = 0; m_cq[p] = 0; m_cnt[p] = 0;
    end
  endtask

  task automatic model_step();
    bit go, all_lk;
    bit rise[NP];
    int a, mn;
    go = start && !abort;
    m_dec = 0;
    for (int p = 0; p < NP; p++) begin
      rise[p] = confirm[p] && !m_cq[p];
      m_cq[p] = confirm[p];
      m_rej[p] = 0;
    end
    if (m_phase == 0 || !go) begin
      for (int p = 0; p < NP; p++) begin m_lk[p] = 0; m_cnt[p] = 0; end
      m_final = 0; m_to = 0; m_ticks = 0;
      m_phase = (m_phase == 0 && go) ? 1 : 0;
    end else if (m_phase == 1) begin
      all_lk = 1;
      for (int p = 0; p < NP; p++) if (!m_lk[p]) all_lk = 0;
      for (int p = 0; p < NP; p++) begin
        if (rise[p] && !m_lk[p]) begin
          a = int'(amount[p*CW +: CW]);
          if (a >= MINS && a <= MAXS) begin m_lk[p] = 1; m_cnt[p] = a; end
          else m_rej[p] = 1;
        end
      end
`ifdef DECISION_TIMEOUT_EN
      if (m_ticks == TMO - 1)
        for (int p = 0; p < NP; p++)
          if (!m_lk[p]) begin m_lk[p] = 1; m_cnt[p] = DEF; m_to = 1; end
`endif
      m_ticks++;
      if (all_lk) m_phase = 2;
    end else if (m_phase == 2) begin
      mn = m_cnt[0];
      for (int p = 1; p < NP; p++) if (m_cnt[p] < mn) mn = m_cnt[p];
      m_final = mn; m_dec = 1; m_phase = 3;
    end
  endtask

  always @(posedge clk or negedge rst) begin
    if (!rst) model_reset();
    else model_step();
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic compare();
    logic [NP-1:0] el, er;
    logic [NP*CW-1:0] epc;
    for (int p = 0; p < NP; p++) begin
      el[p] = m_lk[p]; er[p] = m_rej[p];
      epc[p*CW +: CW] = CW'(m_cnt[p]);
    end
    check("model.locked", 32'(locked), 32'(el));
    check("model.reject", 32'(reject), 32'(er));
    check("model.player_counts", 32'(player_counts), 32'(epc));
    check("model.final_count", 32'(final_count), 32'(m_final));
    check("model.decided", 32'(decided), 32'(m_dec));
    check("model.timed_out", 32'(timed_out), 32'(m_to));
  endtask

  always @(negedge clk) if (chk_en) compare();

  task automatic step();
    @(negedge clk);
  endtask

  task automatic press(input logic [NP-1:0] m, input int a0, input int a1);
    amount = {CW'(a1), CW'(a0)};
    confirm = m;
    step();
    confirm = '0;
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; abort = 1'b0; amount = '0; confirm = '0;
    repeat (2) step();
    check("reset.locked", 32'(locked), 32'd0);
    check("reset.final", 32'(final_count), 32'd0);
    check("reset.decided", 32'(decided), 32'd0);
    check("reset.counts", 32'(player_counts), 32'd0);
    rst = 1'b1; chk_en = 1;
    step();

    // normal flow: P0=4, P1=2 three cycles later
    start = 1'b1; step();
    press(2'b01, 4, 0);
    check("normal.lock0", 32'(locked), 32'd1);
    step(); step();
    press(2'b10, 4, 2);
    check("normal.lock_both", 32'(locked), 32'd3);
    step();
    check("normal.resolve_no_dec", 32'(decided), 32'd0);
    step();
    check("normal.decided", 32'(decided), 32'd1);
    check("normal.final", 32'(final_count), 32'd2);
    step();
    check("normal.decided_once", 32'(decided), 32'd0);
    check("normal.final_held", 32'(final_count), 32'd2);
    start = 1'b0; step();
    check("normal.idle_clear", 32'(locked), 32'd0);

    // range check
    start = 1'b1; step();
    press(2'b01, 0, 0);
    check("range.rej0", 32'(reject), 32'd1);
    check("range.unlocked0", 32'(locked), 32'd0);
    step();
    check("range.rej_pulse", 32'(reject), 32'd0);
    press(2'b01, 6, 0);
    check("range.rej6", 32'(reject), 32'd1);
    step();
    press(2'b01, 5, 0);
    check("range.lock5", 32'(locked), 32'd1);
    check("range.count5", 32'(player_counts[CW-1:0]), 32'd5);
    check("range.no_rej", 32'(reject), 32'd0);
    step();
    press(2'b10, 5, 4);
    step(); step();
    check("range.final", 32'(final_count), 32'd4);
    start = 1'b0; step();

    // simultaneous confirm
    start = 1'b1; step();
    press(2'b11, 3, 3);
    check("simul.locked", 32'(locked), 32'd3);
    step(); step();
    check("simul.decided", 32'(decided), 32'd1);
    check("simul.final", 32'(final_count), 32'd3);
    start = 1'b0; step();

    // held confirm then amount change
    start = 1'b1; step();
    amount = {CW'(0), CW'(2)}; confirm = 2'b01;
    repeat (10) step();
    check("held.locked", 32'(locked), 32'd1);
    check("held.count", 32'(player_counts[CW-1:0]), 32'd2);
    amount = {CW'(0), CW'(4)}; step();
    check("held.count_kept", 32'(player_counts[CW-1:0]), 32'd2);
    confirm = '0; step();
    press(2'b10, 4, 5);
    step(); step();
    check("held.final", 32'(final_count), 32'd2);
    start = 1'b0; step();

    // abort, then reset in RESOLVE
    start = 1'b1; step();
    press(2'b01, 4, 0);
    check("abort.pre", 32'(locked), 32'd1);
    abort = 1'b1; step();
    check("abort.cleared", 32'(locked), 32'd0);
    check("abort.no_dec", 32'(decided), 32'd0);
    abort = 1'b0; step();
    press(2'b11, 2, 3);
    step();
    #1 rst = 1'b0;
    #1;
    check("rst.locked", 32'(locked), 32'd0);
    check("rst.counts", 32'(player_counts), 32'd0);
    check("rst.final", 32'(final_count), 32'd0);
    check("rst.decided", 32'(decided), 32'd0);
    start = 1'b0;
    step(); rst = 1'b1; step();

`ifdef DECISION_TIMEOUT_EN
    start = 1'b1; step();
    press(2'b01, 1, 0);
    repeat (18) step();
    check("tmo.before", 32'(locked), 32'd1);
    step();
    check("tmo.forced", 32'(locked), 32'd3);
    check("tmo.timed_out", 32'(timed_out), 32'd1);
    check("tmo.default", 32'(player_counts[2*CW-1:CW]), 32'd3);
    step(); step();
    check("tmo.decided", 32'(decided), 32'd1);
    check("tmo.final", 32'(final_count), 32'd1);
    start = 1'b0; step();
    check("tmo.clear", 32'(timed_out), 32'd0);
`endif

    // random play
    for (int c = 0; c < 4000; c++) begin
      abort = ($urandom_range(0, 49) == 0);
      if (start) start = ($urandom_range(0, 39) != 0);
      else start = ($urandom_range(0, 2) == 0);
      for (int p = 0; p < NP; p++) begin
        confirm[p] = ($urandom_range(0, 3) == 0);
        amount[p*CW +: CW] = CW'($urandom_range(0, 7));
      end
      step();
    end

    chk_en = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
